// File: rtl/regfile_write_arbiter_if.sv
// Write-request and register-file write-port bundle for regfile_write_arbiter.
interface regfile_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        trap_req;
  logic [31:0] trap_epc;
  logic        uart_valid;
  logic        uart_flag;
  logic [7:0]  uart_data;
  logic        clr_flags;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  rf_src;
  logic        hold_req;
  logic        trap_pending;
  logic        uart_full;
  logic        trap_overflow;
  logic        uart_overrun;

  modport master (
    output wb_we, wb_addr, wb_data, trap_req, trap_epc,
           uart_valid, uart_flag, uart_data, clr_flags,
    input  rf_we, rf_waddr, rf_wdata, rf_src, hold_req,
           trap_pending, uart_full, trap_overflow, uart_overrun
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, trap_req, trap_epc,
           uart_valid, uart_flag, uart_data, clr_flags,
    output rf_we, rf_waddr, rf_wdata, rf_src, hold_req,
           trap_pending, uart_full, trap_overflow, uart_overrun
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB, trap EPC capture and UART bytes.
// WB always wins; trap and UART are buffered with starvation-driven bubble requests.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [4:0]  UART_REG1    = 5'd2,
  parameter logic [4:0]  UART_REG2    = 5'd3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  bus
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned UW = 8;
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] K0_ADDR = AW'(26);
  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_WB   = 2'b01;
  localparam logic [1:0] SRC_TRAP = 2'b10;
  localparam logic [1:0] SRC_UART = 2'b11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [UW-1:0] data;
  } uart_entry_t;

  logic              trap_vld_q;
  logic [DW-1:0]     trap_epc_q;
  uart_entry_t       fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              hold_q, full_q, ovf_q, ovr_q;

  logic wb_eff, trap_drain, trap_bypass, trap_capture, trap_drop;
  logic uart_slot, uart_pop, uart_bypass, uart_push, uart_drop;
  logic any_grant, pending;
  uart_entry_t uart_in;

  // Grant decisions: WB > held trap > new trap > FIFO head > new UART byte
  always_comb begin
    wb_eff       = bus.wb_we && (bus.wb_addr != '0);
    trap_drain   = !wb_eff && trap_vld_q;
    trap_bypass  = !wb_eff && !trap_vld_q && bus.trap_req;
    trap_capture = bus.trap_req && !trap_bypass && (!trap_vld_q || trap_drain);
    trap_drop    = bus.trap_req && trap_vld_q && !trap_drain;
    uart_slot    = !wb_eff && !trap_vld_q && !bus.trap_req;
    uart_pop     = uart_slot && (cnt_q != 2'd0);
    uart_bypass  = uart_slot && (cnt_q == 2'd0) && bus.uart_valid;
    uart_push    = bus.uart_valid && !uart_bypass && ((cnt_q != 2'd2) || uart_pop);
    uart_drop    = bus.uart_valid && !uart_bypass && (cnt_q == 2'd2) && !uart_pop;
    uart_in.addr = bus.uart_flag ? UART_REG2 : UART_REG1;
    uart_in.data = bus.uart_data;
    any_grant    = trap_drain || trap_bypass || uart_pop || uart_bypass;
    pending      = trap_vld_q || (cnt_q != 2'd0);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (uart_push && !uart_pop)      cnt_d = cnt_q + 2'd1;
    else if (!uart_push && uart_pop) cnt_d = cnt_q - 2'd1;
  end

  // Counts cycles a buffered write waits; any trap/UART grant restarts it
  always_comb begin
    starve_d = '0;
    if (!any_grant && pending)
      starve_d = (starve_q == '1) ? starve_q : starve_q + CW'(1);
  end

  // Write-port mux, combinational so granted writes land in the same cycle
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    bus.rf_src   = SRC_NONE;
    if (wb_eff) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.wb_addr;
      bus.rf_wdata = bus.wb_data;
      bus.rf_src   = SRC_WB;
    end else if (trap_vld_q) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = K0_ADDR;
      bus.rf_wdata = trap_epc_q;
      bus.rf_src   = SRC_TRAP;
    end else if (bus.trap_req) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = K0_ADDR;
      bus.rf_wdata = bus.trap_epc;
      bus.rf_src   = SRC_TRAP;
    end else if (cnt_q != 2'd0) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = fifo_q[rd_ptr_q].addr;
      bus.rf_wdata = DW'(fifo_q[rd_ptr_q].data);
      bus.rf_src   = SRC_UART;
    end else if (bus.uart_valid) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = uart_in.addr;
      bus.rf_wdata = DW'(uart_in.data);
      bus.rf_src   = SRC_UART;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_vld_q <= 1'b0;
      trap_epc_q <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      starve_q   <= '0;
      hold_q     <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (trap_capture) begin
        trap_vld_q <= 1'b1;
        trap_epc_q <= bus.trap_epc;
      end else if (trap_drain) begin
        trap_vld_q <= 1'b0;
      end
      if (uart_push) begin
        fifo_q[wr_ptr_q] <= uart_in;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (uart_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == 2'd2);
      starve_q <= starve_d;
      hold_q   <= (starve_d >= CW'(STARVE_LIMIT));
      // A drop in the same cycle as clr_flags leaves the flag set
      if (trap_drop)          ovf_q <= 1'b1;
      else if (bus.clr_flags) ovf_q <= 1'b0;
      if (uart_drop)          ovr_q <= 1'b1;
      else if (bus.clr_flags) ovr_q <= 1'b0;
    end
  end

  assign bus.hold_req      = hold_q;
  assign bus.trap_pending  = trap_vld_q;
  assign bus.uart_full     = full_q;
  assign bus.trap_overflow = ovf_q;
  assign bus.uart_overrun  = ovr_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scoreboard bench for regfile_write_arbiter: per-cycle expected writes
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  regfile_write_arbiter_if bus();

  regfile_write_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [38:0] exp_q [$];   // {src, addr, data} expected in the current cycle

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic expect_wr(input logic [1:0] src, input logic [4:0] addr, input logic [31:0] data);
    exp_q.push_back({src, addr, data});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_we = 1'b0;  bus.wb_addr = '0;  bus.wb_data = '0;
    bus.trap_req = 1'b0; bus.trap_epc = '0;
    bus.uart_valid = 1'b0; bus.uart_flag = 1'b0; bus.uart_data = '0;
    bus.clr_flags = 1'b0;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_we = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
    if (addr != 5'd0) expect_wr(2'b01, addr, data);
  endtask

  task automatic uart(input logic flag, input logic [7:0] data);
    bus.uart_valid = 1'b1; bus.uart_flag = flag; bus.uart_data = data;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rf_we"},    32'(bus.rf_we), 32'd0);
    chk({tag, "_rf_waddr"}, 32'(bus.rf_waddr), 32'd0);
    chk({tag, "_rf_wdata"}, bus.rf_wdata, 32'd0);
    chk({tag, "_rf_src"},   32'(bus.rf_src), 32'd0);
    chk({tag, "_status"},   32'({bus.hold_req, bus.trap_pending, bus.uart_full,
                                 bus.trap_overflow, bus.uart_overrun}), 32'd0);
  endtask

  // Monitor: one expected write per cycle at most; any other write is an error
  initial begin
    logic [38:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (bus.rf_we === 1'b1 && {bus.rf_src, bus.rf_waddr, bus.rf_wdata} === e) pass_cnt++;
        else $display("FAIL write: got we=%b src=%b addr=%0d data=%h want src=%b addr=%0d data=%h",
                      bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata, e[38:37], e[36:32], e[31:0]);
      end else if (bus.rf_we !== 1'b0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got we=%b src=%b addr=%0d data=%h want we=0",
                 bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata);
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // WB and trap in the same cycle: WB now, trap from holding register next cycle
    wb(5'd5, 32'h0000_1234);
    bus.trap_req = 1'b1; bus.trap_epc = 32'hDEAD_BEEC;
    tick();
    chk("trap_pending_after_capture", 32'(bus.trap_pending), 32'd1);
    idle();
    expect_wr(2'b10, 5'd26, 32'hDEAD_BEEC);
    tick();
    chk("trap_pending_after_drain", 32'(bus.trap_pending), 32'd0);

    // UART bypass on an idle port
    uart(1'b1, 8'hA5);
    expect_wr(2'b11, 5'd3, 32'h0000_00A5);
    tick();
    idle();
    chk("uart_full_after_bypass", 32'(bus.uart_full), 32'd0);

    // Three UART bytes under continuous WB: two buffered, third dropped
    wb(5'd7, 32'h111); uart(1'b0, 8'h11); tick();
    chk("uart_full_one_entry", 32'(bus.uart_full), 32'd0);
    wb(5'd7, 32'h112); uart(1'b0, 8'h22); tick();
    chk("uart_full_two_entries", 32'(bus.uart_full), 32'd1);
    wb(5'd7, 32'h113); uart(1'b1, 8'h33); tick();
    chk("uart_overrun_set", 32'(bus.uart_overrun), 32'd1);
    bus.uart_valid = 1'b0;
    wb(5'd7, 32'h114); bus.clr_flags = 1'b1; tick();
    chk("uart_overrun_cleared", 32'(bus.uart_overrun), 32'd0);
    idle();
    expect_wr(2'b11, 5'd2, 32'h11); tick();
    expect_wr(2'b11, 5'd2, 32'h22); tick();
    chk("uart_full_after_drain", 32'(bus.uart_full), 32'd0);
    tick();

    // Starvation: one UART entry buffered behind continuous WB
    wb(5'd9, 32'h900); uart(1'b0, 8'h5C); tick();
    bus.uart_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      wb(5'd9, 32'h900 + 32'(i));
      tick();
    end
    chk("hold_req_after_7_denied", 32'(bus.hold_req), 32'd0);
    wb(5'd9, 32'h908); tick();
    chk("hold_req_after_8_denied", 32'(bus.hold_req), 32'd1);
    idle();
    expect_wr(2'b11, 5'd2, 32'h5C);
    #1;
    chk("hold_req_in_grant_cycle", 32'(bus.hold_req), 32'd1);
    tick();
    chk("hold_req_after_grant", 32'(bus.hold_req), 32'd0);

    // Two traps under WB: first held, second dropped (set beats clr_flags)
    wb(5'd10, 32'hA); bus.trap_req = 1'b1; bus.trap_epc = 32'h100; tick();
    chk("trap_pending_held", 32'(bus.trap_pending), 32'd1);
    wb(5'd10, 32'hB); bus.trap_epc = 32'h200; bus.clr_flags = 1'b1; tick();
    chk("trap_overflow_set_beats_clr", 32'(bus.trap_overflow), 32'd1);
    chk("trap_pending_still_held", 32'(bus.trap_pending), 32'd1);
    idle();
    wb(5'd0, 32'hFFFF);
    expect_wr(2'b10, 5'd26, 32'h100);
    tick();
    chk("trap_pending_after_wb0", 32'(bus.trap_pending), 32'd0);
    idle();
    bus.clr_flags = 1'b1; tick();
    chk("trap_overflow_cleared", 32'(bus.trap_overflow), 32'd0);
    idle();

    // Reset mid-operation discards FIFO and trap holding register
    wb(5'd11, 32'hB0); uart(1'b0, 8'h01); tick();
    wb(5'd11, 32'hB1); uart(1'b0, 8'h02); bus.trap_req = 1'b1; bus.trap_epc = 32'h300; tick();
    chk("pre_reset_full_pending", 32'({bus.uart_full, bus.trap_pending}), 32'd3);
    idle();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk_reset_outputs("post_release");

    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL leftover_expected: got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
